// File: rtl/temporal_bundler.sv
// Temporal bundler: majority-vote accumulation of WINDOW spatial HVs
// into one temporal HV, with valid/ready handshakes on both sides.
module temporal_bundler #(
    parameter int DIMENSIONS = 5,
    parameter int WINDOW     = 4,
    parameter int CNT_W      = $clog2(WINDOW + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIMENSIONS-1:0] hvin,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [DIMENSIONS-1:0] hvout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      win_count
);

    typedef enum logic {
        ACCUM,
        OUTPUT
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      counter  [DIMENSIONS];
    logic [CNT_W-1:0]      cnt_next [DIMENSIONS];
    logic [DIMENSIONS-1:0] first_hv;
    logic [DIMENSIONS-1:0] maj;
    logic                  accept;
    logic                  last;
    logic                  handshake;

    assign accept    = in_ready && in_valid && !clear;
    assign last      = accept && (win_count == CNT_W'(WINDOW - 1));
    assign handshake = (state == OUTPUT) && out_ready;

    // Per-dimension counts including this cycle's bit, and the majority vote
    always_comb begin
        for (int d = 0; d < DIMENSIONS; d++) begin
            cnt_next[d] = counter[d] + CNT_W'(hvin[d]);
        end
        maj = first_hv;
        for (int d = 0; d < DIMENSIONS; d++) begin
            if (2 * int'(cnt_next[d]) > WINDOW) begin
                maj[d] = 1'b1;
            end else if (2 * int'(cnt_next[d]) < WINDOW) begin
                maj[d] = 1'b0;
            end else begin
                // Tie: the first HV of the window breaks it
                maj[d] = (win_count == '0) ? hvin[d] : first_hv[d];
            end
        end
    end

    // Window FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            hvout     <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (last) begin
                        state     <= OUTPUT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        hvout     <= maj;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Counter, window-length and first-HV bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
            first_hv  <= '0;
            for (int d = 0; d < DIMENSIONS; d++) begin
                counter[d] <= '0;
            end
        end else if (handshake || (state == ACCUM && clear)) begin
            win_count <= '0;
            for (int d = 0; d < DIMENSIONS; d++) begin
                counter[d] <= '0;
            end
        end else if (accept) begin
            win_count <= win_count + 1'b1;
            if (win_count == '0) begin
                first_hv <= hvin;
            end
            for (int d = 0; d < DIMENSIONS; d++) begin
                counter[d] <= cnt_next[d];
            end
        end
    end

endmodule

// File: tb/tb_temporal_bundler.sv
// Self-checking bench for temporal_bundler: reference model plus
// scoreboard of expected window results, directed and random stimulus.
module tb_temporal_bundler;

    localparam int D  = 5;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [D-1:0]  hvin = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          clear = 1'b0;
    logic [D-1:0]  hvout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] win_count;

    int n_vec = 0;
    int n_bad = 0;

    temporal_bundler #(
        .DIMENSIONS(D),
        .WINDOW    (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hvin     (hvin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .hvout    (hvout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .win_count(win_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [D-1:0] win_q[$];
    logic [D-1:0] sb[$];
    logic         m_out = 1'b0;
    logic [D-1:0] m_hv = '0;

    function automatic logic [D-1:0] majority();
        logic [D-1:0] r;
        int c;
        for (int d = 0; d < D; d++) begin
            c = 0;
            foreach (win_q[i]) c += int'(win_q[i][d]);
            if (2 * c > W)      r[d] = 1'b1;
            else if (2 * c < W) r[d] = 1'b0;
            else                r[d] = win_q[0][d];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = 1'b0;
            m_hv  = '0;
            win_q.delete();
            sb.delete();
        end else if (m_out) begin
            if (out_ready) begin
                m_out = 1'b0;
                win_q.delete();
            end
        end else if (clear) begin
            win_q.delete();
        end else if (in_valid) begin
            win_q.push_back(hvin);
            if (win_q.size() == W) begin
                m_hv = majority();
                sb.push_back(m_hv);
                m_out = 1'b1;
            end
        end
    end

    // Compare outputs away from the active edge
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(!m_out));
        chk("out_valid", 32'(out_valid), 32'(m_out));
        chk("win_count", 32'(win_count), 32'(win_q.size()));
        chk("hvout", 32'(hvout), 32'(m_hv));
        if (rst_n && m_out && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_result", 32'(hvout), 32'(sb.pop_front()));
        end
    end

    task automatic cyc(input logic iv, input logic [D-1:0] h,
                       input logic clr, input logic ordy);
        in_valid  = iv;
        hvin      = h;
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic tie_window(input bit gaps);
        logic [D-1:0] v[4];
        v[0] = 5'b01101;
        v[1] = 5'b00111;
        v[2] = 5'b00011;
        v[3] = 5'b00011;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                cyc(1'b0, 5'b11111, 1'b0, 1'b0);
                cyc(1'b0, 5'b10000, 1'b0, 1'b0);
            end
            cyc(1'b1, v[i], 1'b0, 1'b0);
        end
        chk("tie_valid", 32'(out_valid), 32'd1);
        chk("tie_hv", 32'(hvout), 32'h07);
        chk("tie_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_hv", 32'(hvout), 32'd0);
        chk("rst_cnt", 32'(win_count), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Tie window, then backpressure with stray input
        tie_window(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 5'b11000, 1'b0, 1'b0);
        chk("bp_hv", 32'(hvout), 32'h07);
        chk("bp_cnt", 32'(win_count), 32'd4);
        cyc(1'b1, 5'b11000, 1'b1, 1'b1);
        chk("hs_cnt", 32'(win_count), 32'd0);
        chk("hs_ready", 32'(in_ready), 32'd1);
        chk("hs_hold", 32'(hvout), 32'h07);

        // Clear mid-window
        cyc(1'b1, 5'b01010, 1'b0, 1'b0);
        cyc(1'b1, 5'b01010, 1'b0, 1'b0);
        chk("pre_clr", 32'(win_count), 32'd2);
        cyc(1'b1, 5'b11111, 1'b1, 1'b0);
        chk("post_clr", 32'(win_count), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'b11111, 1'b0, 1'b0);
        chk("clr_hv", 32'(hvout), 32'h1f);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Async reset while in OUTPUT
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'b10101, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_hv", 32'(hvout), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle gaps, starting right after reset
        tie_window(1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), D'($urandom),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 2) == 0));
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/temporal_bundler.md
TEMPORAL_BUNDLER -- requirements
Module: temporal_bundler

Interface
REQ-001 SHALL have parameter DIMENSIONS, default 5, which sets the hypervector width in bits.
REQ-002 SHALL have parameter WINDOW, default 4, which sets the number of spatially bundled HVs per window; legal range is 2 or more.
REQ-003 SHALL have parameter CNT_W, default $clog2(WINDOW+1), which sets the width of each per-dimension counter and of win_count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port hvin, input, DIMENSIONS bits: spatially bundled HV from the upstream bundler stage.
REQ-007 SHALL have port in_valid, input, 1 bit: hvin is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts hvin.
REQ-009 SHALL have port clear, input, 1 bit: synchronous abort of the current window.
REQ-010 SHALL have port hvout, output, DIMENSIONS bits: registered temporal-majority HV.
REQ-011 SHALL have port out_valid, output, 1 bit: hvout is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage consumes hvout.
REQ-013 SHALL have port win_count, output, CNT_W bits: number of HVs accepted in the current window.

Function
REQ-014 SHALL implement two states: ACCUM and OUTPUT.
REQ-015 In ACCUM, SHALL drive in_ready=1 and out_valid=0.
REQ-016 In OUTPUT, SHALL drive in_ready=0 and out_valid=1.
REQ-017 An accept SHALL occur only when in_valid=1 and in_ready=1 are both high on a rising edge.
REQ-018 On each accept, SHALL increment counter[d] by hvin[d] for every d in 0..DIMENSIONS-1, and increment win_count by 1.
REQ-019 On the first accept of a window (win_count=0), SHALL store hvin into a first_hv register.
REQ-020 On the accept that makes win_count reach WINDOW, SHALL register hvout[d] per REQ-021, transition to OUTPUT on the same edge, and assert out_valid in the following cycle (latency of 1 cycle from the final accept).
REQ-021 Majority rule: hvout[d]=1 if 2*count[d] > WINDOW; hvout[d]=0 if 2*count[d] < WINDOW; if 2*count[d] = WINDOW, hvout[d]=first_hv[d]. Here count[d] includes the final accepted bit.
REQ-022 Counter arithmetic SHALL be unsigned, CNT_W bits wide, and SHALL never overflow, because win_count is at most WINDOW.
REQ-023 In OUTPUT, SHALL hold hvout and out_valid stable until out_ready=1.
REQ-024 On the OUTPUT handshake (out_valid and out_ready both high), SHALL zero all counters and win_count and return to ACCUM; in_ready SHALL rise in the next cycle, and no HV is accepted on the handshake cycle.
REQ-025 In ACCUM, clear=1 SHALL zero the counters and win_count and discard the cycle's hvin, even if in_valid=1; clear takes priority over accept.
REQ-026 In OUTPUT, clear=1 SHALL be ignored; the pending hvout SHALL still be delivered.
REQ-027 hvout SHALL retain its last value after the handshake until the next window completes.
REQ-028 With in_valid=0, the state, counters and win_count SHALL hold.

Reset
REQ-029 While rst_n=0, the block SHALL be in ACCUM with counters=0, win_count=0, first_hv=0, hvout=0, out_valid=0, and in_ready=1 once rst_n is released.
REQ-030 Reset asserted mid-window or in OUTPUT SHALL discard all partial state immediately and asynchronously.
REQ-031 The first accept after reset release SHALL be treated as the first accept of a window.

Verification
REQ-032 Scenario, WINDOW=3, DIMENSIONS=5: accept 01101, 00111, 00011 -> out_valid=1 one cycle after the third accept, hvout=00111, in_ready=0.
REQ-033 Scenario, WINDOW=4 (tie case): accept 01101, 00111, 00011, 00011 -> bit2 count=2 (tie) takes first_hv bit2=1, so hvout=00111.
REQ-034 Scenario, backpressure: hold out_ready=0 for 5 cycles after REQ-033, with in_valid=1 and new hvin -> hvout stays 00111, no accept, win_count stays 4; raise out_ready -> win_count=0, in_ready=1 next cycle.
REQ-035 Scenario, clear: accept two HVs (win_count=2), then pulse clear with in_valid=1 -> win_count=0 and the HV is not counted; next window of 4 HVs equal to 11111 -> hvout=11111.
REQ-036 Scenario, reset: assert rst_n=0 in OUTPUT, asynchronously between edges -> out_valid=0, hvout=00000, in_ready=1 immediately.
REQ-037 Scenario, idle gaps: insert in_valid=0 cycles between accepts -> result identical to REQ-033.
